// File: rtl/branch_predict_unit.sv
// Branch resolution in EX plus a PC-indexed 2-bit BHT predicting at IF.
// Also drives the PC-source select and flush, and keeps saturating branch and miss statistics.
module branch_predict_unit #(
  parameter int XLEN       = 32,
  parameter int IDX_W      = 6,
  parameter bit PREDICT_EN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             z,
  input  logic             c,
  input  logic             s,
  input  logic             v,
  output logic [1:0]       redirect_sel,
  output logic             mispredict,
  output logic             actual_taken,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_miss
);

  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_TGT  = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_CORR = 2'b11;

  logic [1:0] bht [DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_br;
  logic             is_jal;
  logic             is_jalr;
  logic             cond;
  logic             br_miss;
  logic             upd;
  logic [1:0]       cur;
  logic [1:0]       nxt;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign is_br   = ex_opcode == OP_BRANCH;
  assign is_jal  = ex_opcode == OP_JAL;
  assign is_jalr = ex_opcode == OP_JALR;

  // Upper and byte-offset PC bits never reach the table index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    unique case (ex_func3)
      3'b000:  cond = z;
      3'b001:  cond = ~z;
      3'b100:  cond = s ^ v;
      3'b101:  cond = ~(s ^ v);
      3'b110:  cond = ~c;
      3'b111:  cond = c;
      default: cond = 1'b0;
    endcase
  end

  assign br_miss = cond ^ ex_pred_taken;

  always_comb begin
    redirect_sel = SEL_SEQ;
    mispredict   = 1'b0;
    actual_taken = 1'b0;
    if (!rst && ex_valid) begin
      unique case (1'b1)
        is_br: begin
          actual_taken = cond;
          mispredict   = br_miss;
          if (br_miss)
            redirect_sel = cond ? SEL_TGT : SEL_CORR;
        end
        is_jal: begin
          redirect_sel = SEL_TGT;
          mispredict   = 1'b1;
          actual_taken = 1'b1;
        end
        is_jalr: begin
          redirect_sel = SEL_ALU;
          mispredict   = 1'b1;
          actual_taken = 1'b1;
        end
        default: begin
          redirect_sel = SEL_SEQ;
        end
      endcase
    end
  end

  assign pred_taken = PREDICT_EN && !rst && bht[if_idx][1];

  assign upd = PREDICT_EN && ex_valid && is_br;
  assign cur = bht[ex_idx];

  always_comb begin
    nxt = cur;
    if (cond && cur != 2'b11)
      nxt = cur + 2'b01;
    else if (!cond && cur != 2'b00)
      nxt = cur - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (upd) begin
      bht[ex_idx] <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_miss     <= '0;
    end else if (ex_valid && is_br) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + 1'b1;
      if (br_miss && stat_miss != '1)
        stat_miss <= stat_miss + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed checks of branch_predict_unit: default build, static-predict
// build and a narrow-statistics build, all sharing one stimulus stream.
module tb_branch_predict_unit;

  localparam logic [4:0] BR   = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] OP   = 5'b01100;

  localparam logic [31:0] PA = 32'h0000_0104;
  localparam logic [31:0] PB = 32'h0000_0204;
  localparam logic [31:0] PC0 = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        z, c, s, v;

  logic        pred, pred_s, pred_n;
  logic [1:0]  sel, sel_s, sel_n;
  logic        mp, mp_s, mp_n;
  logic        at, at_s, at_n;
  logic [15:0] sb, sm, sb_s, sm_s;
  logic [3:0]  sb_n, sm_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .z(z), .c(c), .s(s), .v(v),
    .redirect_sel(sel), .mispredict(mp), .actual_taken(at),
    .stat_branches(sb), .stat_miss(sm)
  );

  branch_predict_unit #(.PREDICT_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_s),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .z(z), .c(c), .s(s), .v(v),
    .redirect_sel(sel_s), .mispredict(mp_s), .actual_taken(at_s),
    .stat_branches(sb_s), .stat_miss(sm_s)
  );

  branch_predict_unit #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .z(z), .c(c), .s(s), .v(v),
    .redirect_sel(sel_n), .mispredict(mp_n), .actual_taken(at_n),
    .stat_branches(sb_n), .stat_miss(sm_n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one EX op at the negedge; outputs settle 1ns later.
  task automatic ex_set(input logic val, input logic [4:0] op,
                        input logic [2:0] f3, input logic [31:0] pc,
                        input logic pt, input logic [3:0] zcsv);
    @(negedge clk);
    ex_valid = val; ex_opcode = op; ex_func3 = f3;
    ex_pc = pc; ex_pred_taken = pt;
    {z, c, s, v} = zcsv;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0; ex_opcode = OP;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_pc = PA;
    ex_valid = 1'b1; ex_opcode = JAL; ex_func3 = 3'b000;
    ex_pc = PA; ex_pred_taken = 1'b0; {z, c, s, v} = 4'b1000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pred", {31'b0, pred}, 32'd0);
    chk("rst_sel", {30'b0, sel}, 32'd0);
    chk("rst_mp", {31'b0, mp}, 32'd0);
    chk("rst_at", {31'b0, at}, 32'd0);
    rst = 1'b0;
    idle();
    chk("init_pred", {31'b0, pred}, 32'd0);
    chk("init_sb", {16'b0, sb}, 32'd0);

    // BEQ taken against a not-taken prediction
    ex_set(1'b1, BR, 3'b000, PA, 1'b0, 4'b1000);
    chk("t1_old_pred", {31'b0, pred}, 32'd0);
    chk("t1_sel", {30'b0, sel}, 32'd1);
    chk("t1_mp", {31'b0, mp}, 32'd1);
    chk("t1_at", {31'b0, at}, 32'd1);
    idle();
    chk("t1_new_pred", {31'b0, pred}, 32'd1);
    chk("t5_static_pred", {31'b0, pred_s}, 32'd0);
    if_pc = PB; #1;
    chk("alias_pred", {31'b0, pred}, 32'd1);
    if_pc = PA;

    ex_set(1'b1, BR, 3'b000, PA, 1'b1, 4'b1000);
    chk("t2_match_sel", {30'b0, sel}, 32'd0);
    chk("t2_match_mp", {31'b0, mp}, 32'd0);
    ex_set(1'b1, BR, 3'b000, PA, 1'b1, 4'b1000);
    ex_set(1'b1, BR, 3'b000, PA, 1'b1, 4'b0000);
    chk("t2_sat_pred", {31'b0, pred}, 32'd1);
    chk("t2_nt_sel", {30'b0, sel}, 32'd3);
    chk("t2_nt_mp", {31'b0, mp}, 32'd1);
    chk("t2_nt_at", {31'b0, at}, 32'd0);
    ex_set(1'b1, BR, 3'b000, PA, 1'b1, 4'b0000);
    chk("t2_from11_pred", {31'b0, pred}, 32'd1);
    idle();
    chk("t2_from10_pred", {31'b0, pred}, 32'd0);
    chk("t2_sb", {16'b0, sb}, 32'd5);
    chk("t2_sm", {16'b0, sm}, 32'd3);

    // func3 sweep with z=0 c=0 s=1 v=0: taken for 001, 100, 110
    for (int f = 0; f < 8; f++) begin
      logic [7:0] exp_t;
      exp_t = 8'b0101_0010;
      ex_set(1'b1, BR, f[2:0], PC0, 1'b0, 4'b0010);
      chk($sformatf("t3_at_f%0d", f), {31'b0, at}, {31'b0, exp_t[f]});
      chk($sformatf("t3_sel_f%0d", f), {30'b0, sel},
          exp_t[f] ? 32'd1 : 32'd0);
    end
    idle();
    chk("t3_sb", {16'b0, sb}, 32'd13);
    chk("t3_sm", {16'b0, sm}, 32'd6);

    ex_set(1'b1, JAL, 3'b000, PA, 1'b1, 4'b0000);
    chk("t4_jal_sel", {30'b0, sel}, 32'd1);
    chk("t4_jal_mp", {31'b0, mp}, 32'd1);
    chk("t4_jal_at", {31'b0, at}, 32'd1);
    ex_set(1'b1, JALR, 3'b000, PA, 1'b0, 4'b1000);
    chk("t4_jalr_sel", {30'b0, sel}, 32'd2);
    chk("t4_jalr_mp", {31'b0, mp}, 32'd1);
    ex_set(1'b0, BR, 3'b000, PA, 1'b0, 4'b1000);
    chk("t4_inv_sel", {30'b0, sel}, 32'd0);
    chk("t4_inv_mp", {31'b0, mp}, 32'd0);
    chk("t4_inv_at", {31'b0, at}, 32'd0);
    ex_set(1'b1, OP, 3'b000, PA, 1'b1, 4'b1000);
    chk("t4_op_sel", {30'b0, sel}, 32'd0);
    chk("t4_op_mp", {31'b0, mp}, 32'd0);
    idle();
    chk("t4_pred_kept", {31'b0, pred}, 32'd0);
    chk("t4_sb", {16'b0, sb}, 32'd13);
    chk("t4_sm", {16'b0, sm}, 32'd6);

    // Same-index update and read: old value now, new value next cycle
    ex_set(1'b1, BR, 3'b001, PA, 1'b0, 4'b0000);
    chk("t5_same_old", {31'b0, pred}, 32'd0);
    idle();
    chk("t5_same_new", {31'b0, pred}, 32'd1);
    chk("t5_static_pred2", {31'b0, pred_s}, 32'd0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("t6_rst_sbn", {28'b0, sb_n}, 32'd0);
    for (int i = 0; i < 20; i++)
      ex_set(1'b1, BR, 3'b000, PA, 1'b0, 4'b1000);
    idle();
    chk("t6_sbn_sat", {28'b0, sb_n}, 32'd15);
    chk("t6_smn_sat", {28'b0, sm_n}, 32'd15);
    chk("t6_sb", {16'b0, sb}, 32'd20);
    chk("t6_sm", {16'b0, sm}, 32'd20);
    chk("t6_pred_sat", {31'b0, pred}, 32'd1);

    // Reset coinciding with a not-taken update: the update is lost
    ex_set(1'b1, BR, 3'b000, PA, 1'b1, 4'b0000);
    rst = 1'b1; #1;
    chk("t6_rst_mp", {31'b0, mp}, 32'd0);
    chk("t6_rst_pred", {31'b0, pred}, 32'd0);
    @(negedge clk); rst = 1'b0; ex_valid = 1'b0; #1;
    chk("t6_post_sb", {16'b0, sb}, 32'd0);
    chk("t6_post_sm", {16'b0, sm}, 32'd0);
    chk("t6_post_pred", {31'b0, pred}, 32'd0);
    ex_set(1'b1, BR, 3'b000, PA, 1'b0, 4'b1000);
    idle();
    chk("t6_weak_nt", {31'b0, pred}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
